lock_seq_ctrl: RTL and testbench
================================

// Module: lock_seq_ctrl
// PURPOSE
//  Sequencing FSM for the board password lock. Consumes one-cycle digit/button event pulses from the
//  switch/button front end, assembles a 4-digit BCD code, compares it to a stored key, and drives
//  WAIT/INPUT/UNLOCK/ERROR/ALARM/SETKEY. Uses a 1 ms strobe for timeouts. Feeds the 7-seg/LED display block.
// PARAMETERS
//  DEFAULT_KEY  16'h1234  key loaded at reset, 4 BCD digits, first-entered digit in [15:12]
//  MAX_ERR      3         consecutive wrong codes that trigger ALARM (1..3)
//  UNLOCK_MS    5000      UNLOCK hold time in ms
//  ERROR_MS     1000      ERROR display time in ms
//  ALARM_MS     10000     ALARM duration in ms
//  IDLE_MS      10000     inactivity timeout in INPUT/SETKEY in ms
//  TIMER_W      14        ms timer width; must hold max(*_MS)
// PORTS
//  CLK          in   1   system clock
//  RESET        in   1   synchronous, active-high reset
//  TICK_1MS     in   1   one-CLK strobe every 1 ms
//  DIGIT_VALID  in   1   one-CLK pulse: new digit on DIGIT_IN
//  DIGIT_IN     in   4   digit value, 0..9 valid
//  OK_PULSE     in   1   one-CLK pulse, OK button
//  BACK_PULSE   in   1   one-CLK pulse, backspace button
//  ADMIN_PULSE  in   1   one-CLK pulse, admin button
//  STATE        out  3   WAIT=000 INPUT=001 UNLOCK=010 ERROR=011 ALARM=100 SETKEY=101
//  CODE         out  16  entered digits, newest in [3:0]
//  CODE_CNT     out  3   digits entered, 0..4
//  ERR_CNT      out  2   consecutive wrong-code count
//  UNLOCKED     out  1   high iff STATE==UNLOCK
//  ALARM_ON     out  1   high iff STATE==ALARM
// BEHAVIOUR
//  - Reset: STATE=WAIT, CODE=0, CODE_CNT=0, ERR_CNT=0, key=DEFAULT_KEY, timer=0, UNLOCKED=0, ALARM_ON=0.
//    RESET mid-operation aborts everything, including SETKEY and ALARM, and restores DEFAULT_KEY.
//  - All outputs registered; effect of an event pulse is visible on the CLK edge after it is sampled.
//  - One event per cycle, priority OK > BACK > DIGIT > ADMIN; lower-priority pulses in that cycle are dropped.
//  - DIGIT_IN > 9 ignored. Digit accept: CODE<={CODE[11:0],DIGIT_IN}, CODE_CNT+1; ignored when CODE_CNT==4.
//  - BACK: CODE<={4'h0,CODE[15:4]}, CODE_CNT-1; ignored when CODE_CNT==0.
//  - Timer: cleared on every STATE change and on every accepted event in INPUT/SETKEY; +1 per TICK_1MS.
//    Timeout fires on the edge where a TICK_1MS makes the timer equal the state's limit.
//  - WAIT: valid digit -> INPUT, digit captured on the same edge (CODE_CNT=1). OK/BACK/ADMIN ignored.
//  - INPUT: digits/BACK as above; OK with CODE_CNT<4 ignored (no error). ADMIN ignored.
//    OK with CODE_CNT==4, CODE==key -> UNLOCK, ERR_CNT=0.
//    Mismatch -> ERR_CNT+1; new ERR_CNT==MAX_ERR -> ALARM, else -> ERROR.
//    IDLE_MS timeout -> WAIT. CODE and CODE_CNT cleared on every exit from INPUT.
//  - UNLOCK: OK -> WAIT (relock). ADMIN -> SETKEY. UNLOCK_MS timeout -> WAIT.
//  - SETKEY: digits/BACK as INPUT. OK with CODE_CNT==4 -> key<=CODE, -> WAIT.
//    OK with CODE_CNT<4 ignored. ADMIN or IDLE_MS timeout -> WAIT, key unchanged. CODE cleared on exit.
//  - ERROR: all events ignored; ERROR_MS timeout -> WAIT, ERR_CNT kept.
//  - ALARM: all events ignored; ALARM_MS timeout -> WAIT, ERR_CNT=0.
//  - ERR_CNT saturates at MAX_ERR; it is cleared only by a correct code, ALARM exit, or RESET.
//  - Illegal STATE encoding -> WAIT on the next edge, CODE/CODE_CNT cleared.
// TESTING
//  1 Reset, digits 1,2,3,4, OK -> STATE=010, UNLOCKED=1 one CLK after OK. After 5000 ticks -> STATE=000.
//  2 Enter 1,2,3,5, OK -> STATE=011, ERR_CNT=1. Repeat twice -> third OK gives STATE=100, ALARM_ON=1.
//    After 10000 ticks -> STATE=000, ERR_CNT=0. Events during ALARM ignored.
//  3 Enter 1,2,9, BACK, 3,4, OK -> CODE=16'h1234 before OK, then UNLOCK.
//    BACK at CODE_CNT=0 and a 5th digit are ignored. Digit 4'hA is ignored.
//  4 Unlock, ADMIN -> STATE=101. Enter 9,8,7,6, OK -> WAIT. Entering 1,2,3,4 now errors; 9,8,7,6 unlocks.
//    RESET -> 1,2,3,4 works again.
//  5 Same-cycle OK+DIGIT_VALID at CODE_CNT=3 -> OK ignored, digit dropped, CODE_CNT stays 3.
//    INPUT idle for 10000 ticks -> WAIT, CODE=0.
//  6 RESET asserted in SETKEY, ERROR, or mid-entry -> next edge: all outputs at reset values.

Source files
------------

// File: rtl/lock_seq_ctrl.sv
// Password-lock sequencer: assembles a 4-digit BCD code from button events, compares it
// to a stored key and walks WAIT/INPUT/UNLOCK/ERROR/ALARM/SETKEY with ms timeouts.
module lock_seq_ctrl #(
    parameter logic [15:0] DEFAULT_KEY = 16'h1234,
    parameter int unsigned MAX_ERR     = 3,
    parameter int unsigned UNLOCK_MS   = 5000,
    parameter int unsigned ERROR_MS    = 1000,
    parameter int unsigned ALARM_MS    = 10000,
    parameter int unsigned IDLE_MS     = 10000,
    parameter int unsigned TIMER_W     = 14
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TICK_1MS,
    input  logic        DIGIT_VALID,
    input  logic [3:0]  DIGIT_IN,
    input  logic        OK_PULSE,
    input  logic        BACK_PULSE,
    input  logic        ADMIN_PULSE,
    output logic [2:0]  STATE,
    output logic [15:0] CODE,
    output logic [2:0]  CODE_CNT,
    output logic [1:0]  ERR_CNT,
    output logic        UNLOCKED,
    output logic        ALARM_ON
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'b000,
        S_INPUT  = 3'b001,
        S_UNLOCK = 3'b010,
        S_ERROR  = 3'b011,
        S_ALARM  = 3'b100,
        S_SETKEY = 3'b101
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        code_q, code_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic [15:0]        key_q, key_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               unlocked_q, unlocked_d;
    logic               alarm_q, alarm_d;

    logic               ev_ok, ev_back, ev_dig, ev_adm;
    logic               dig_ok, accepted, tick_hit;
    logic [TIMER_W-1:0] limit;
    logic [1:0]         err_inc;

    // One event per cycle, priority OK > BACK > DIGIT > ADMIN
    always_comb begin
        ev_ok   = OK_PULSE;
        ev_back = !OK_PULSE && BACK_PULSE;
        ev_dig  = !OK_PULSE && !BACK_PULSE && DIGIT_VALID;
        ev_adm  = !OK_PULSE && !BACK_PULSE && !DIGIT_VALID && ADMIN_PULSE;
        dig_ok  = ev_dig && (DIGIT_IN <= 4'd9);
    end

    // Per-state timeout limit and the tick that reaches it
    always_comb begin
        limit = '0;
        case (state_q)
            S_INPUT, S_SETKEY: limit = TIMER_W'(IDLE_MS);
            S_UNLOCK:          limit = TIMER_W'(UNLOCK_MS);
            S_ERROR:           limit = TIMER_W'(ERROR_MS);
            S_ALARM:           limit = TIMER_W'(ALARM_MS);
            default:           limit = '0;
        endcase
        tick_hit = TICK_1MS && ((timer_q + TIMER_W'(1)) == limit);
        err_inc  = (32'(err_q) >= MAX_ERR) ? err_q : err_q + 2'd1;
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        key_d    = key_q;
        timer_d  = TICK_1MS ? timer_q + TIMER_W'(1) : timer_q;
        accepted = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (dig_ok) begin
                    state_d = S_INPUT;
                    code_d  = {12'h000, DIGIT_IN};
                    cnt_d   = 3'd1;
                end
            end
            S_INPUT, S_SETKEY: begin
                if (ev_ok) begin
                    if (cnt_q == 3'd4) begin
                        if (state_q == S_SETKEY) begin
                            key_d   = code_q;
                            state_d = S_WAIT;
                        end else if (code_q == key_q) begin
                            state_d = S_UNLOCK;
                            err_d   = 2'd0;
                        end else begin
                            err_d   = err_inc;
                            state_d = (32'(err_inc) == MAX_ERR) ? S_ALARM : S_ERROR;
                        end
                    end
                end else if (ev_back) begin
                    if (cnt_q != 3'd0) begin
                        code_d   = {4'h0, code_q[15:4]};
                        cnt_d    = cnt_q - 3'd1;
                        accepted = 1'b1;
                    end
                end else if (dig_ok && (cnt_q != 3'd4)) begin
                    code_d   = {code_q[11:0], DIGIT_IN};
                    cnt_d    = cnt_q + 3'd1;
                    accepted = 1'b1;
                end else if (ev_adm && (state_q == S_SETKEY)) begin
                    state_d = S_WAIT;
                end else if (tick_hit && !ev_dig && !ev_adm) begin
                    state_d = S_WAIT;
                end
                // Entry buffer never survives leaving the entry states
                if (state_d != state_q) begin
                    code_d = 16'h0000;
                    cnt_d  = 3'd0;
                end
            end
            S_UNLOCK: begin
                if (ev_ok)         state_d = S_WAIT;
                else if (ev_adm)   state_d = S_SETKEY;
                else if (tick_hit) state_d = S_WAIT;
            end
            S_ERROR: begin
                if (tick_hit) state_d = S_WAIT;
            end
            S_ALARM: begin
                if (tick_hit) begin
                    state_d = S_WAIT;
                    err_d   = 2'd0;
                end
            end
            default: begin
                state_d = S_WAIT;
                code_d  = 16'h0000;
                cnt_d   = 3'd0;
            end
        endcase

        if ((state_d != state_q) || accepted) begin
            timer_d = '0;
        end
        unlocked_d = (state_d == S_UNLOCK);
        alarm_d    = (state_d == S_ALARM);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_WAIT;
            code_q     <= 16'h0000;
            cnt_q      <= 3'd0;
            err_q      <= 2'd0;
            key_q      <= DEFAULT_KEY;
            timer_q    <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            key_q      <= key_d;
            timer_q    <= timer_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign STATE    = state_q;
    assign CODE     = code_q;
    assign CODE_CNT = cnt_q;
    assign ERR_CNT  = err_q;
    assign UNLOCKED = unlocked_q;
    assign ALARM_ON = alarm_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl: hand-computed expectations for entry, unlock,
// error/alarm escalation, key change, priority, timeouts and reset aborts.
module tb_lock_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        TICK_1MS = 1'b0;
    logic        DIGIT_VALID = 1'b0;
    logic [3:0]  DIGIT_IN = 4'h0;
    logic        OK_PULSE = 1'b0;
    logic        BACK_PULSE = 1'b0;
    logic        ADMIN_PULSE = 1'b0;
    logic [2:0]  STATE;
    logic [15:0] CODE;
    logic [2:0]  CODE_CNT;
    logic [1:0]  ERR_CNT;
    logic        UNLOCKED;
    logic        ALARM_ON;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] WAIT_S = 3'b000, INPUT_S = 3'b001, UNLOCK_S = 3'b010,
                           ERROR_S = 3'b011, ALARM_S = 3'b100, SETKEY_S = 3'b101;

    lock_seq_ctrl dut (
        .CLK(CLK), .RESET(RESET), .TICK_1MS(TICK_1MS),
        .DIGIT_VALID(DIGIT_VALID), .DIGIT_IN(DIGIT_IN),
        .OK_PULSE(OK_PULSE), .BACK_PULSE(BACK_PULSE), .ADMIN_PULSE(ADMIN_PULSE),
        .STATE(STATE), .CODE(CODE), .CODE_CNT(CODE_CNT), .ERR_CNT(ERR_CNT),
        .UNLOCKED(UNLOCKED), .ALARM_ON(ALARM_ON)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: bench did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic [15:0] code,
                              input logic [2:0] cnt, input logic [1:0] err);
        check_val({tag, ".state"}, 16'(STATE), 16'(st));
        check_val({tag, ".code"}, CODE, code);
        check_val({tag, ".cnt"}, 16'(CODE_CNT), 16'(cnt));
        check_val({tag, ".err"}, 16'(ERR_CNT), 16'(err));
        check_val({tag, ".unl"}, 16'(UNLOCKED), 16'(st == UNLOCK_S));
        check_val({tag, ".alm"}, 16'(ALARM_ON), 16'(st == ALARM_S));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        DIGIT_IN = d;
        DIGIT_VALID = 1'b1;
        step();
        DIGIT_VALID = 1'b0;
    endtask

    task automatic ok();
        OK_PULSE = 1'b1;
        step();
        OK_PULSE = 1'b0;
    endtask

    task automatic back();
        BACK_PULSE = 1'b1;
        step();
        BACK_PULSE = 1'b0;
    endtask

    task automatic admin();
        ADMIN_PULSE = 1'b1;
        step();
        ADMIN_PULSE = 1'b0;
    endtask

    task automatic ticks(input int n);
        TICK_1MS = 1'b1;
        repeat (n) step();
        TICK_1MS = 1'b0;
    endtask

    task automatic enter4(input logic [15:0] c);
        digit(c[15:12]);
        digit(c[11:8]);
        digit(c[7:4]);
        digit(c[3:0]);
    endtask

    initial begin
        step();
        do_reset();
        check_outs("rst", WAIT_S, 16'h0, 3'd0, 2'd0);

        // 1: correct code unlocks, UNLOCK times out after exactly 5000 ticks
        enter4(16'h1234);
        check_outs("t1_entry", INPUT_S, 16'h1234, 3'd4, 2'd0);
        ok();
        check_outs("t1_unlock", UNLOCK_S, 16'h0, 3'd0, 2'd0);
        ticks(4999);
        check_val("t1_unlock_4999", 16'(STATE), 16'(UNLOCK_S));
        ticks(1);
        check_outs("t1_relock", WAIT_S, 16'h0, 3'd0, 2'd0);

        // 2: three wrong codes escalate to ALARM
        enter4(16'h1235);
        ok();
        check_outs("t2_err1", ERROR_S, 16'h0, 3'd0, 2'd1);
        digit(4'd1);
        check_val("t2_err_ignore", 16'(CODE_CNT), 16'd0);
        ticks(999);
        check_val("t2_err_999", 16'(STATE), 16'(ERROR_S));
        ticks(1);
        check_outs("t2_err_exit", WAIT_S, 16'h0, 3'd0, 2'd1);
        enter4(16'h1235);
        ok();
        check_outs("t2_err2", ERROR_S, 16'h0, 3'd0, 2'd2);
        ticks(1000);
        enter4(16'h1235);
        ok();
        check_outs("t2_alarm", ALARM_S, 16'h0, 3'd0, 2'd3);
        digit(4'd1);
        ok();
        admin();
        check_outs("t2_alarm_ign", ALARM_S, 16'h0, 3'd0, 2'd3);
        ticks(9999);
        check_val("t2_alarm_9999", 16'(STATE), 16'(ALARM_S));
        ticks(1);
        check_outs("t2_alarm_exit", WAIT_S, 16'h0, 3'd0, 2'd0);

        // 3: backspace, invalid digit, 5th digit
        back();
        check_outs("t3_back_wait", WAIT_S, 16'h0, 3'd0, 2'd0);
        digit(4'd1);
        digit(4'hA);
        check_outs("t3_hex_ign", INPUT_S, 16'h0001, 3'd1, 2'd0);
        back();
        back();
        check_outs("t3_back_zero", INPUT_S, 16'h0, 3'd0, 2'd0);
        digit(4'd1);
        digit(4'd2);
        digit(4'd9);
        back();
        check_outs("t3_back", INPUT_S, 16'h0012, 3'd2, 2'd0);
        digit(4'd3);
        digit(4'd4);
        digit(4'd5);
        check_outs("t3_fifth", INPUT_S, 16'h1234, 3'd4, 2'd0);
        ok();
        check_val("t3_unlock", 16'(STATE), 16'(UNLOCK_S));
        ok();
        check_val("t3_relock_ok", 16'(STATE), 16'(WAIT_S));

        // 4: change key through SETKEY
        enter4(16'h1234);
        ok();
        admin();
        check_outs("t4_setkey", SETKEY_S, 16'h0, 3'd0, 2'd0);
        enter4(16'h9876);
        check_val("t4_newcode", CODE, 16'h9876);
        ok();
        check_outs("t4_stored", WAIT_S, 16'h0, 3'd0, 2'd0);
        enter4(16'h1234);
        ok();
        check_outs("t4_old_key", ERROR_S, 16'h0, 3'd0, 2'd1);
        ticks(1000);
        enter4(16'h9876);
        ok();
        check_outs("t4_new_key", UNLOCK_S, 16'h0, 3'd0, 2'd0);
        do_reset();
        check_outs("t4_rst", WAIT_S, 16'h0, 3'd0, 2'd0);
        enter4(16'h1234);
        ok();
        check_val("t4_default_back", 16'(STATE), 16'(UNLOCK_S));
        do_reset();

        // 5: same-cycle OK + digit, then idle timeout
        digit(4'd1);
        digit(4'd2);
        digit(4'd3);
        DIGIT_IN = 4'd4;
        DIGIT_VALID = 1'b1;
        OK_PULSE = 1'b1;
        step();
        DIGIT_VALID = 1'b0;
        OK_PULSE = 1'b0;
        check_outs("t5_prio", INPUT_S, 16'h0123, 3'd3, 2'd0);
        ticks(9999);
        check_val("t5_idle_9999", 16'(STATE), 16'(INPUT_S));
        ticks(1);
        check_outs("t5_idle", WAIT_S, 16'h0, 3'd0, 2'd0);

        // 6: reset aborts SETKEY, ERROR and mid-entry
        enter4(16'h1234);
        ok();
        admin();
        digit(4'd9);
        check_outs("t6_pre_setkey", SETKEY_S, 16'h0009, 3'd1, 2'd0);
        do_reset();
        check_outs("t6_rst_setkey", WAIT_S, 16'h0, 3'd0, 2'd0);
        enter4(16'h5555);
        ok();
        check_val("t6_pre_err", 16'(STATE), 16'(ERROR_S));
        do_reset();
        check_outs("t6_rst_err", WAIT_S, 16'h0, 3'd0, 2'd0);
        digit(4'd7);
        digit(4'd8);
        do_reset();
        check_outs("t6_rst_entry", WAIT_S, 16'h0, 3'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
